// File: rtl/dpram_pkg.sv
// Shared definitions for the true dual-port RAM: read-during-write mode codes,
// controller states and the per-lane even-parity helper.
package dpram_pkg;

  localparam int RDW_READ_FIRST  = 0;
  localparam int RDW_WRITE_FIRST = 1;

  // Upper bounds for the parity helper; callers zero-extend and truncate.
  localparam int MAX_DATA_WIDTH = 256;
  localparam int MAX_LANES      = 64;

  typedef enum logic {
    CLEAR,
    READY
  } state_e;

  // Even parity per lane: the bit that makes the lane plus parity have an even count of ones.
  function automatic logic [MAX_LANES-1:0] lane_parity(input logic [MAX_DATA_WIDTH-1:0] data,
                                                       input int                        byte_width);
    logic [MAX_LANES-1:0] par;
    par = '0;
    for (int b = 0; b < MAX_DATA_WIDTH; b++) begin
      if ((b / byte_width) < MAX_LANES) par[b / byte_width] ^= data[b];
    end
    return par;
  endfunction

endpackage

// File: rtl/dpram_rd_stage.sv
// Per-port read output stage: registered read data (held between reads),
// one-cycle valid strobe and optional parity check of the returned word.
module dpram_rd_stage
  import dpram_pkg::*;
#(
  parameter  int DATA_WIDTH = 32,
  parameter  int BYTE_WIDTH = 8,
  parameter  bit PARITY_EN  = 1'b0,
  localparam int NUM_LANES  = DATA_WIDTH / BYTE_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rd_en_i,
  input  logic [DATA_WIDTH-1:0] rd_data_i,
  input  logic [NUM_LANES-1:0]  rd_par_i,
  input  logic                  rd_oor_i,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  rvalid_o,
  output logic                  parity_err_o
);

  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  rvalid_q;
  logic                  parity_err_q, parity_err_d;

  // NOTE: every combinational output gets a default before any condition, so no latch is inferred.
  always_comb begin
    rdata_d = rdata_q;
    if (rd_en_i) rdata_d = rd_data_i;
  end

  if (PARITY_EN) begin : g_parity
    assign parity_err_d = rd_en_i && !rd_oor_i &&
                          (NUM_LANES'(lane_parity(MAX_DATA_WIDTH'(rd_data_i), BYTE_WIDTH)) != rd_par_i);
  end else begin : g_no_parity
    logic unused_par;
    assign unused_par   = ^{rd_par_i, rd_oor_i};
    assign parity_err_d = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q      <= '0;
      rvalid_q     <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      rdata_q      <= rdata_d;
      rvalid_q     <= rd_en_i;
      parity_err_q <= parity_err_d;
    end
  end

  assign rdata_o      = rdata_q;
  assign rvalid_o     = rvalid_q;
  assign parity_err_o = parity_err_q;

endmodule

// File: rtl/dual_port_ram_tdp.sv
// True dual-port RAM with byte enables, post-reset clear sequence and collision flag.
// Define DPRAM_PARITY_EN to store and check one even-parity bit per byte lane.
module dual_port_ram_tdp
  import dpram_pkg::*;
#(
  parameter  int DATA_WIDTH = 32,
  parameter  int BYTE_WIDTH = 8,
  parameter  int ADDR_WIDTH = 4,
  parameter  int DEPTH      = 16,
  parameter  int RDW_MODE   = RDW_READ_FIRST,
  localparam int NUM_LANES  = DATA_WIDTH / BYTE_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en_0,
  input  logic                  we_0,
  input  logic [NUM_LANES-1:0]  be_0,
  input  logic [ADDR_WIDTH-1:0] addr_0,
  input  logic [DATA_WIDTH-1:0] wdata_0,
  input  logic                  en_1,
  input  logic                  we_1,
  input  logic [NUM_LANES-1:0]  be_1,
  input  logic [ADDR_WIDTH-1:0] addr_1,
  input  logic [DATA_WIDTH-1:0] wdata_1,
  output logic [DATA_WIDTH-1:0] rdata_0,
  output logic [DATA_WIDTH-1:0] rdata_1,
  output logic                  rvalid_0,
  output logic                  rvalid_1,
  output logic                  collision,
  output logic                  init_busy,
  output logic                  parity_err_0,
  output logic                  parity_err_1
);

  localparam logic [ADDR_WIDTH:0]   DEPTH_W   = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
`ifdef DPRAM_PARITY_EN
  localparam bit PARITY_EN = 1'b1;
`else
  localparam bit PARITY_EN = 1'b0;
`endif

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  collision_q;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
`ifdef DPRAM_PARITY_EN
  logic [NUM_LANES-1:0]  par_mem [DEPTH];
`endif

  logic [1:0]                 p_en, p_we, in_range, wr, rd;
  logic [1:0][NUM_LANES-1:0]  p_be, rd_par;
  logic [1:0][ADDR_WIDTH-1:0] p_addr;
  logic [1:0][DATA_WIDTH-1:0] p_wdata, rd_word, rdata_a;
  logic [1:0]                 rvalid_a, perr_a;
  logic                       ready, same_addr;

  assign p_en    = {en_1, en_0};
  assign p_we    = {we_1, we_0};
  assign p_be    = {be_1, be_0};
  assign p_addr  = {addr_1, addr_0};
  assign p_wdata = {wdata_1, wdata_0};

  assign ready     = (state_q == READY);
  assign same_addr = (addr_0 == addr_1);

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      in_range[p] = ({1'b0, p_addr[p]} < DEPTH_W);
      wr[p]       = ready && p_en[p] && p_we[p] && in_range[p];
      rd[p]       = ready && p_en[p] && !p_we[p];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_ADDR) begin
          state_d = READY;
          cnt_d   = '0;
        end
      end
      READY: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= CLEAR;
      cnt_q       <= '0;
      collision_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      collision_q <= wr[0] && wr[1] && same_addr;
    end
  end

  // NOTE: the array has no reset; the CLEAR sequence zeroes it one word per cycle instead.
  // Port 1 is applied first so port 0's later assignment wins on shared lanes.
  always_ff @(posedge clk) begin
    if (!ready) begin
      mem[cnt_q] <= '0;
`ifdef DPRAM_PARITY_EN
      par_mem[cnt_q] <= '0;
`endif
    end else begin
      for (int p = 1; p >= 0; p--) begin
        for (int i = 0; i < NUM_LANES; i++) begin
          if (wr[p] && p_be[p][i]) begin
            mem[p_addr[p]][i*BYTE_WIDTH +: BYTE_WIDTH] <= p_wdata[p][i*BYTE_WIDTH +: BYTE_WIDTH];
`ifdef DPRAM_PARITY_EN
            par_mem[p_addr[p]][i] <= ^p_wdata[p][i*BYTE_WIDTH +: BYTE_WIDTH];
`endif
          end
        end
      end
    end
  end

  // The array is read before this edge's write lands, giving read-first by default;
  // write-first splices the other port's enabled lanes into the returned word.
  always_comb begin
    rd_word = '0;
    rd_par  = '0;
    for (int p = 0; p < 2; p++) begin
      if (in_range[p]) begin
        rd_word[p] = mem[p_addr[p]];
`ifdef DPRAM_PARITY_EN
        rd_par[p] = par_mem[p_addr[p]];
`endif
        if (RDW_MODE == RDW_WRITE_FIRST && wr[1-p] && same_addr) begin
          for (int i = 0; i < NUM_LANES; i++) begin
            if (p_be[1-p][i]) begin
              rd_word[p][i*BYTE_WIDTH +: BYTE_WIDTH] = p_wdata[1-p][i*BYTE_WIDTH +: BYTE_WIDTH];
              rd_par[p][i] = ^p_wdata[1-p][i*BYTE_WIDTH +: BYTE_WIDTH];
            end
          end
        end
      end
    end
  end

  for (genvar p = 0; p < 2; p++) begin : g_rd
    dpram_rd_stage #(
      .DATA_WIDTH (DATA_WIDTH),
      .BYTE_WIDTH (BYTE_WIDTH),
      .PARITY_EN  (PARITY_EN)
    ) u_rd_stage (
      .clk          (clk),
      .rst_n        (rst_n),
      .rd_en_i      (rd[p]),
      .rd_data_i    (rd_word[p]),
      .rd_par_i     (rd_par[p]),
      .rd_oor_i     (!in_range[p]),
      .rdata_o      (rdata_a[p]),
      .rvalid_o     (rvalid_a[p]),
      .parity_err_o (perr_a[p])
    );
  end

  assign rdata_0      = rdata_a[0];
  assign rdata_1      = rdata_a[1];
  assign rvalid_0     = rvalid_a[0];
  assign rvalid_1     = rvalid_a[1];
  assign parity_err_0 = perr_a[0];
  assign parity_err_1 = perr_a[1];
  assign collision    = collision_q;
  assign init_busy    = (state_q == CLEAR);

endmodule
